// File: rtl/int_issue_bank_scheduler.sv
// Occupancy-tracking scheduler for the banked integer issue queue: per-bank entry
// counters, emptiest-bank-first lane steering and dispatch backpressure.
module int_issue_bank_scheduler #(
    parameter int unsigned BANK_NUM  = 4,
    parameter int unsigned BANK_SIZE = 8,
    localparam int unsigned CNT_W    = $clog2(BANK_SIZE) + 1,
    localparam int unsigned IDX_W    = $clog2(BANK_NUM)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [BANK_NUM-1:0]       enq_i,
    input  logic [BANK_NUM-1:0]       deq_i,
    input  logic                      redirect_i,
    input  logic [BANK_NUM*CNT_W-1:0] flush_num_i,
    output logic [BANK_NUM*IDX_W-1:0] order_o,
    output logic                      full_o,
    output logic [BANK_NUM*CNT_W-1:0] bank_cnt_o,
    output logic                      err_o
);

    localparam int unsigned SUM_W = CNT_W + 2;
    localparam int unsigned PRI_W = IDX_W + 1;
    localparam logic signed [SUM_W-1:0] ZERO_S   = '0;
    localparam logic signed [SUM_W-1:0] MAX_S    = SUM_W'(BANK_SIZE);
    localparam logic [CNT_W-1:0]        FULL_CNT = CNT_W'(BANK_SIZE);
    localparam logic [IDX_W-1:0]        RR_LAST  = IDX_W'(BANK_NUM - 1);
    localparam logic [PRI_W-1:0]        NUM_P    = PRI_W'(BANK_NUM);

    logic [CNT_W-1:0]        cnt_q [BANK_NUM];
    logic [CNT_W-1:0]        cnt_d [BANK_NUM];
    logic [IDX_W-1:0]        rr_q;
    logic [IDX_W-1:0]        rr_d;
    logic                    err_q;
    logic                    err_d;
    logic signed [SUM_W-1:0] sum_c  [BANK_NUM];
    logic [PRI_W-1:0]        prio_c [BANK_NUM];
    logic [IDX_W-1:0]        rank_c [BANK_NUM];
    logic                    full_c;

    // Net occupancy change per bank; out-of-range results clamp and flag err.
    always_comb begin
        err_d = err_q;
        for (int i = 0; i < BANK_NUM; i++) begin
            sum_c[i] = SUM_W'(cnt_q[i]) + SUM_W'(enq_i[i]) - SUM_W'(deq_i[i])
                     - (redirect_i ? SUM_W'(flush_num_i[i*CNT_W +: CNT_W]) : '0);
            if (sum_c[i] < ZERO_S) begin
                cnt_d[i] = '0;
                err_d    = 1'b1;
            end else if (sum_c[i] > MAX_S) begin
                cnt_d[i] = FULL_CNT;
                err_d    = 1'b1;
            end else begin
                cnt_d[i] = sum_c[i][CNT_W-1:0];
            end
        end
    end

    // Tie-break pointer advances whenever any bank accepted an instruction.
    always_comb begin
        rr_d = rr_q;
        if (|enq_i) begin
            rr_d = (rr_q == RR_LAST) ? '0 : rr_q + IDX_W'(1);
        end
    end

    // Rotating tie-break priority: (k - rr) mod BANK_NUM, one extra bit avoids wrap.
    always_comb begin
        for (int k = 0; k < BANK_NUM; k++) begin
            prio_c[k] = PRI_W'(k) + NUM_P - {1'b0, rr_q};
            if (prio_c[k] >= NUM_P) begin
                prio_c[k] = prio_c[k] - NUM_P;
            end
        end
    end

    // Each bank's lane is the number of banks that outrank it; keys are unique,
    // so the ranks always form a permutation.
    always_comb begin
        for (int i = 0; i < BANK_NUM; i++) begin
            rank_c[i] = '0;
            for (int k = 0; k < BANK_NUM; k++) begin
                if ((k != i) &&
                    ((cnt_q[k] < cnt_q[i]) ||
                     ((cnt_q[k] == cnt_q[i]) && (prio_c[k] < prio_c[i])))) begin
                    rank_c[i] = rank_c[i] + IDX_W'(1);
                end
            end
        end
    end

    always_comb begin
        full_c = 1'b0;
        for (int i = 0; i < BANK_NUM; i++) begin
            if (cnt_q[i] == FULL_CNT) begin
                full_c = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BANK_NUM; i++) begin
                cnt_q[i] <= '0;
            end
            rr_q  <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < BANK_NUM; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            rr_q  <= rr_d;
            err_q <= err_d;
        end
    end

    always_comb begin
        for (int i = 0; i < BANK_NUM; i++) begin
            order_o[i*IDX_W +: IDX_W]    = rank_c[i];
            bank_cnt_o[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end

    assign full_o = full_c;
    assign err_o  = err_q;

endmodule

// File: tb/tb_int_issue_bank_scheduler.sv
// Bench for int_issue_bank_scheduler: directed vector table, overflow sequence,
// then randomized traffic against a sort-based reference model.
module tb_int_issue_bank_scheduler;

    localparam int BN = 4;
    localparam int BS = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  enq;
    logic [3:0]  deq;
    logic        redir;
    logic [15:0] flush;
    logic [7:0]  order;
    logic        full;
    logic [15:0] bank_cnt;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    int_issue_bank_scheduler #(.BANK_NUM(4), .BANK_SIZE(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .enq_i       (enq),
        .deq_i       (deq),
        .redirect_i  (redir),
        .flush_num_i (flush),
        .order_o     (order),
        .full_o      (full),
        .bank_cnt_o  (bank_cnt),
        .err_o       (err)
    );

    typedef struct {
        logic        rst;
        logic [3:0]  enq;
        logic [3:0]  deq;
        logic        redir;
        logic [15:0] flush;
        logic [15:0] cnt;
        logic        full;
        logic        err;
        logic        chk_ord;
        logic [7:0]  ord;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic r, input logic [3:0] e, input logic [3:0] d,
                                input logic rd, input logic [15:0] f, input logic [15:0] c,
                                input logic fu, input logic er, input logic co,
                                input logic [7:0] o);
        vec_t v;
        v.rst = r; v.enq = e; v.deq = d; v.redir = rd; v.flush = f;
        v.cnt = c; v.full = fu; v.err = er; v.chk_ord = co; v.ord = o;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic [3:0] e, input logic [3:0] d,
                         input logic rd, input logic [15:0] f);
        rst = r; enq = e; deq = d; redir = rd; flush = f;
        @(posedge clk);
        #1;
    endtask

    // Reference model: plain integer counters, order derived by sorting.
    int m_cnt[BN];
    int m_rr;
    bit m_err;

    task automatic model_step(input logic r, input logic [3:0] e, input logic [3:0] d,
                              input logic rd, input logic [15:0] f);
        int v;
        if (r) begin
            for (int i = 0; i < BN; i++) m_cnt[i] = 0;
            m_rr  = 0;
            m_err = 0;
        end else begin
            for (int i = 0; i < BN; i++) begin
                v = m_cnt[i] + int'(e[i]) - int'(d[i]) - (rd ? int'(f[i*4 +: 4]) : 0);
                if (v < 0) begin v = 0; m_err = 1; end
                if (v > BS) begin v = BS; m_err = 1; end
                m_cnt[i] = v;
            end
            if (e != 4'b0) m_rr = (m_rr + 1) % BN;
        end
    endtask

    function automatic logic [7:0] model_order();
        int key[BN];
        bit used[BN];
        int best;
        logic [7:0] o;
        o = '0;
        for (int k = 0; k < BN; k++) begin
            key[k]  = m_cnt[k] * BN + ((k - m_rr + BN) % BN);
            used[k] = 0;
        end
        for (int p = 0; p < BN; p++) begin
            best = -1;
            for (int k = 0; k < BN; k++)
                if (!used[k] && (best < 0 || key[k] < key[best])) best = k;
            used[best] = 1;
            o[best*2 +: 2] = 2'(p);
        end
        return o;
    endfunction

    function automatic logic [15:0] model_cnt();
        logic [15:0] c;
        for (int i = 0; i < BN; i++) c[i*4 +: 4] = 4'(m_cnt[i]);
        return c;
    endfunction

    function automatic logic model_full();
        logic fu = 1'b0;
        for (int i = 0; i < BN; i++) if (m_cnt[i] == BS) fu = 1'b1;
        return fu;
    endfunction

    initial begin
        logic        r;
        logic [3:0]  e;
        logic [3:0]  d;
        logic        rd;
        logic [15:0] f;
        vec_t        v;

        // Directed table: inputs for one cycle, expected state the cycle after.
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 16'h0, 16'h0000, 0, 0, 1, 8'hE4));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 16'h0, 16'h0000, 0, 0, 1, 8'hE4));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h1111, 0, 0, 1, 8'h93));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h2222, 0, 0, 1, 8'h4E));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h3333, 0, 0, 1, 8'h39));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h4444, 0, 0, 1, 8'hE4));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h5555, 0, 0, 1, 8'h93));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h6666, 0, 0, 1, 8'h4E));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h7777, 0, 0, 1, 8'h39));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h8888, 1, 0, 1, 8'hE4));
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 16'h0, 16'h0000, 0, 0, 1, 8'hE4));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h1111, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h2222, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h5, 4'h0, 0, 16'h0, 16'h2323, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h5, 4'h0, 0, 16'h0, 16'h2424, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h5, 4'h0, 0, 16'h0, 16'h2525, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h0, 16'h2625, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h0, 16'h2725, 0, 0, 1, 8'h36));
        tbl.push_back(mk(0, 4'h4, 4'h4, 0, 16'h0, 16'h2725, 0, 0, 1, 8'h72));
        tbl.push_back(mk(0, 4'h4, 4'h4, 0, 16'h0, 16'h2725, 0, 0, 1, 8'h72));
        tbl.push_back(mk(0, 4'h4, 4'h4, 0, 16'h0, 16'h2725, 0, 0, 1, 8'h36));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h0, 16'h2726, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h0, 16'h2727, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h0, 16'h2728, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h1, 0, 16'h0, 16'h2728, 1, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h1, 0, 16'h0, 16'h2727, 0, 0, 0, 8'h00));
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 16'h0, 16'h0000, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h1111, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h7, 4'h0, 0, 16'h0, 16'h1222, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h7, 4'h0, 0, 16'h0, 16'h1333, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h3, 4'h0, 0, 16'h0, 16'h1344, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h0, 16'h1345, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h0, 16'h1346, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h1, 1, 16'h1042, 16'h0303, 0, 0, 1, 8'h27));
        tbl.push_back(mk(0, 4'h0, 4'h4, 0, 16'h0, 16'h0203, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h4, 0, 16'h0, 16'h0103, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h4, 0, 16'h0, 16'h0003, 0, 0, 0, 8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h4, 0, 16'h0, 16'h0003, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 16'h0, 16'h0003, 0, 1, 0, 8'h00));
        tbl.push_back(mk(0, 4'hF, 4'h0, 0, 16'h0, 16'h1114, 0, 1, 0, 8'h00));
        tbl.push_back(mk(1, 4'hF, 4'hF, 1, 16'hFFFF, 16'h0000, 0, 0, 1, 8'hE4));
        tbl.push_back(mk(0, 4'h0, 4'h0, 1, 16'h000F, 16'h0000, 0, 1, 1, 8'hE4));
        tbl.push_back(mk(1, 4'h0, 4'h0, 0, 16'h0, 16'h0000, 0, 0, 1, 8'hE4));

        for (int n = 0; n < tbl.size(); n++) begin
            v = tbl[n];
            drive(v.rst, v.enq, v.deq, v.redir, v.flush);
            cmp($sformatf("tbl%0d_cnt", n), 32'(bank_cnt), 32'(v.cnt));
            cmp($sformatf("tbl%0d_full", n), 32'(full), 32'(v.full));
            cmp($sformatf("tbl%0d_err", n), 32'(err), 32'(v.err));
            if (v.chk_ord) cmp($sformatf("tbl%0d_order", n), 32'(order), 32'(v.ord));
        end

        // Overflow: ninth enq into bank1 clamps at 8 and raises err.
        for (int n = 1; n <= 9; n++) begin
            drive(0, 4'h2, 4'h0, 0, 16'h0);
            cmp($sformatf("ovf%0d_cnt", n), 32'(bank_cnt), 32'(n > 8 ? 8 * 16 : n * 16));
            cmp($sformatf("ovf%0d_full", n), 32'(full), 32'(n >= 8));
            cmp($sformatf("ovf%0d_err", n), 32'(err), 32'(n > 8));
        end

        // Randomized traffic against the reference model.
        model_step(1, 4'h0, 4'h0, 0, 16'h0);
        drive(1, 4'h0, 4'h0, 0, 16'h0);
        for (int n = 0; n < 3000; n++) begin
            r  = ($urandom_range(0, 99) == 0);
            e  = 4'($urandom);
            rd = ($urandom_range(0, 7) == 0);
            for (int i = 0; i < BN; i++) begin
                d[i] = (m_cnt[i] > 0) ? 1'($urandom) : ($urandom_range(0, 19) == 0);
                f[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15))
                                                          : 4'($urandom_range(0, m_cnt[i]));
            end
            model_step(r, e, d, rd, f);
            drive(r, e, d, rd, f);
            cmp($sformatf("rnd%0d_cnt", n), 32'(bank_cnt), 32'(model_cnt()));
            cmp($sformatf("rnd%0d_full", n), 32'(full), 32'(model_full()));
            cmp($sformatf("rnd%0d_err", n), 32'(err), 32'(m_err));
            cmp($sformatf("rnd%0d_order", n), 32'(order), 32'(model_order()));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
